// File: rtl/fifo_uart_tx_if.sv
// Read-port bundle between the synchronous FIFO and its UART drain stage.
// The drain stage is the master: it requests pops and consumes status/data.
interface fifo_uart_tx_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_rd_en;

  modport master (input fifo_empty, input fifo_rdata, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_rdata, input fifo_rd_en);
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word per frame and serialises it as a UART frame
// (start, LSB-first data, optional parity, 1 or 2 stop bits) on a registered line.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           tx_en_i,
  fifo_uart_tx_if.master fifo,
  output logic           tx_o,
  output logic           busy_o,
  output logic           done_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(WIDTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  state_t             state_r;
  logic [BAUD_W-1:0]  baud_cnt_r;
  logic [IDX_W-1:0]   bit_idx_r;
  logic               stop_cnt_r;
  logic [WIDTH-1:0]   shift_r;
  logic               parity_r;
  logic               tx_r;
  logic               rd_en_r;
  logic               busy_r;
  logic               done_r;

  logic               bit_tick_s;
  logic               stop_last_s;

  function automatic logic parity_f(input logic [WIDTH-1:0] data);
    return (^data) ^ PARITY_ODD;
  endfunction

  assign bit_tick_s  = (baud_cnt_r == BAUD_LAST);
  assign stop_last_s = (stop_cnt_r == STOP_LAST);

  // Frame sequencer; every output is registered with the value of the state being entered.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= '0;
      bit_idx_r  <= '0;
      stop_cnt_r <= 1'b0;
      shift_r    <= '0;
      parity_r   <= 1'b0;
      tx_r       <= 1'b1;
      rd_en_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      rd_en_r <= 1'b0;
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          baud_cnt_r <= '0;
          tx_r       <= 1'b1;
          // Empty is only looked at here, so a frame in flight can never pop.
          if (tx_en_i && !fifo.fifo_empty) begin
            state_r <= ST_POP;
            rd_en_r <= 1'b1;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_POP: begin
          state_r <= ST_LOAD;
        end
        ST_LOAD: begin
          shift_r  <= fifo.fifo_rdata;
          parity_r <= parity_f(fifo.fifo_rdata);
          tx_r     <= 1'b0;
          state_r  <= ST_START;
        end
        ST_START: begin
          if (bit_tick_s) begin
            baud_cnt_r <= '0;
            bit_idx_r  <= '0;
            tx_r       <= shift_r[0];
            state_r    <= ST_DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_tick_s) begin
            baud_cnt_r <= '0;
            if (bit_idx_r == IDX_LAST) begin
              if (PARITY_EN) begin
                tx_r    <= parity_r;
                state_r <= ST_PARITY;
              end else begin
                tx_r       <= 1'b1;
                stop_cnt_r <= 1'b0;
                state_r    <= ST_STOP;
              end
            end else begin
              bit_idx_r <= bit_idx_r + 1'b1;
              shift_r   <= {1'b0, shift_r[WIDTH-1:1]};
              tx_r      <= shift_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_tick_s) begin
            baud_cnt_r <= '0;
            tx_r       <= 1'b1;
            stop_cnt_r <= 1'b0;
            state_r    <= ST_STOP;
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_tick_s) begin
            baud_cnt_r <= '0;
            if (stop_last_s) begin
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              stop_cnt_r <= stop_cnt_r + 1'b1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
            // Armed one cycle early so the pulse lands on the final stop cycle.
            if (stop_last_s && (baud_cnt_r == BAUD_PRE)) begin
              done_r <= 1'b1;
            end else begin
              done_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_o            = tx_r;
  assign busy_o          = busy_r;
  assign done_o          = done_r;
  assign fifo.fifo_rd_en = rd_en_r;

endmodule
